led_blink_counter: RTL and testbench
====================================

Name: led_blink_counter

Overview:
- Free-running prescaler counter that toggles an LED output at a fixed rate derived from the 50 MHz board clock.
- Default behaviour: LED toggles every 0.5 s, giving a 1 Hz square wave, 50 % duty.
- Sits at the top of the board design as a heartbeat/alive indicator.
- No inputs other than clock and reset.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency in Hz (documentation/derivation only).
- HALF_CYCLES, 25_000_000, clock cycles per LED level (half period); legal range 1 .. 2^32-1.
- CNT_W, $clog2(HALF_CYCLES) with minimum 1, counter width (derived localparam, not overridden).

Ports:
- Clk50M  input  1  system clock, 50 MHz, all logic on the rising edge.
- Rst_n  input  1  reset, asynchronous, active-high: 1 = reset asserted. The codebase name is kept; polarity is high.
- led  output  1  LED drive, registered, 1 = LED on.

Behaviour:
- Reset (Rst_n = 1, asynchronous assert): cnt = 0, led = 0, immediately and without waiting for a clock edge.
- Rst_n deassertion is synchronous to Clk50M, guaranteed by the upstream reset generator. The block adds no resynchronizer.
- Each rising edge out of reset:
  - if cnt == HALF_CYCLES-1: cnt <= 0 and led <= ~led;
  - else cnt <= cnt + 1, led holds.
- cnt is an internal unsigned CNT_W-bit register. It never exceeds HALF_CYCLES-1, so no binary wrap occurs.
- Timing after reset release, with edge 1 being the first edge seen with Rst_n = 0:
  - led first rises after edge HALF_CYCLES;
  - led falls after edge 2*HALF_CYCLES;
  - full period is 2*HALF_CYCLES cycles; high and low times are each exactly HALF_CYCLES cycles.
- HALF_CYCLES = 1: cnt stays 0 and led toggles every cycle.
- Reset asserted mid-count: cnt and led return to 0 at once. The count restarts from zero on release, with no memory of phase.
- led is driven directly from a flop; no combinational path from any input.
- Terminal-count compare is a constant equality; no arithmetic overflow handling needed.

Decomposition:
- Shared package (board_pkg): CLK_FREQ_HZ_50M = 50_000_000 and a helper constant/function half_cycles(freq_hz, blink_hz) = freq_hz/(2*blink_hz).
- One sub-module: tick_gen.
  - Parameter HALF_CYCLES; ports Clk50M, Rst_n, tick.
  - Emits a one-cycle pulse when cnt hits terminal count.
- Top led_blink_counter holds only the led toggle flop enabled by tick.

Test Plan:
- Reset hold: Rst_n = 1 for 200 cycles, HALF_CYCLES = 10 -> led = 0 throughout; cnt = 0.
- First toggle: release reset, HALF_CYCLES = 10 -> led = 0 through edge 9, led = 1 after edge 10, led = 0 after edge 20.
- Period/duty: HALF_CYCLES = 10, run 100 cycles -> exactly 10 led edges; every high and low interval is 10 clocks (200 ns at 20 ns period).
- Async reset mid-count: assert Rst_n between clock edges at cnt = 6 while led = 1 -> led = 0 within the same timestep, before the next edge. After release, the next rise comes 10 edges later.
- Degenerate: HALF_CYCLES = 1 -> led toggles on every rising edge after release.
- Default parameters smoke test: HALF_CYCLES = 25_000_000, 2 s simulated -> led rises at 0.5 s, 1.5 s and falls at 1.0 s, 2.0 s (±1 clock) relative to reset release.

Source files
------------

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board-level clock constants and blink-rate helpers
package board_pkg;

  localparam int unsigned CLK_FREQ_HZ_50M = 50_000_000;

  // Clock cycles spent at each LED level for a given blink rate.
  function automatic int unsigned half_cycles(input int unsigned freq_hz,
                                              input int unsigned blink_hz);
    return freq_hz / (2 * blink_hz);
  endfunction

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler emitting a one-cycle tick every HALF_CYCLES clocks
module tick_gen
  import board_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 25_000_000
) (
  input  logic Clk50M,
  input  logic Rst_n,
  output logic tick
);

  localparam int CNT_W = cnt_width(HALF_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt stops at TERM, so the equality compare is the whole terminal-count test.
  assign tick = (cnt == TERM);

  always_ff @(posedge Clk50M or posedge Rst_n) begin
    if (Rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_counter.sv
// rtl/led_blink_counter.sv - heartbeat LED toggled by the prescaler tick
module led_blink_counter
  import board_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_50M,
  parameter int unsigned HALF_CYCLES = half_cycles(CLK_FREQ_HZ, 1)
) (
  input  logic Clk50M,
  input  logic Rst_n,
  output logic led
);

  logic tick;

  tick_gen #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_tick_gen (
    .Clk50M(Clk50M),
    .Rst_n (Rst_n),
    .tick  (tick)
  );

  always_ff @(posedge Clk50M or posedge Rst_n) begin
    if (Rst_n) begin
      led <= 1'b0;
    end else if (tick) begin
      led <= ~led;
    end
  end

endmodule

// File: tb/tb_led_blink_counter.sv
// tb/tb_led_blink_counter.sv - self-checking bench for led_blink_counter
`timescale 1ns/1ps
module tb_led_blink_counter;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  logic led_a, led_b, led_c;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  always #10 clk = ~clk;

  // a: HALF_CYCLES = 10, b: degenerate HALF_CYCLES = 1,
  // c: default derivation with a scaled-down clock (40 Hz -> 20 cycles per level).
  led_blink_counter #(.HALF_CYCLES(10)) dut_a (.Clk50M(clk), .Rst_n(rst_a), .led(led_a));
  led_blink_counter #(.HALF_CYCLES(1))  dut_b (.Clk50M(clk), .Rst_n(rst_b), .led(led_b));
  led_blink_counter #(.CLK_FREQ_HZ(40)) dut_c (.Clk50M(clk), .Rst_n(rst_c), .led(led_c));

  typedef struct {
    int    dut;
    logic  rst;
    int    n;
    logic  exp;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int d, input logic r, input int n,
                              input logic e, input string name);
    vec_t v;
    v.dut = d; v.rst = r; v.n = n; v.exp = e; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic logic led_of(input int d);
    case (d)
      0:       return led_a;
      1:       return led_b;
      default: return led_c;
    endcase
  endfunction

  task automatic set_rst(input int d, input logic r);
    case (d)
      0:       rst_a = r;
      1:       rst_b = r;
      default: rst_c = r;
    endcase
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: led=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive reset on the falling edge, queue the expectation, check after the rising edge.
  task automatic run_edge(input int d, input logic r, input logic e, input string name);
    @(negedge clk);
    set_rst(d, r);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_bit(name, led_of(d), exp_q.pop_front());
  endtask

  initial begin
    int   last_edge;
    int   toggles;
    logic prev;

    add(0, 1'b1, 200, 1'b0, "reset_hold");
    add(0, 1'b0, 9,   1'b0, "first_low");
    add(0, 1'b0, 10,  1'b1, "first_high");
    add(0, 1'b0, 10,  1'b0, "first_fall");
    add(1, 1'b1, 3,   1'b0, "deg_reset");
    for (int k = 1; k <= 8; k++) add(1, 1'b0, 1, logic'(k % 2), "deg_toggle");
    add(2, 1'b1, 2,   1'b0, "dflt_reset");
    add(2, 1'b0, 19,  1'b0, "dflt_low0");
    add(2, 1'b0, 20,  1'b1, "dflt_rise_half");
    add(2, 1'b0, 20,  1'b0, "dflt_fall_one");
    add(2, 1'b0, 20,  1'b1, "dflt_rise_1p5");
    add(2, 1'b0, 1,   1'b0, "dflt_fall_two");

    #1;
    check_bit("reset_initial", led_a, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        run_edge(vecs[i].dut, vecs[i].rst, vecs[i].exp, vecs[i].name);
      end
    end

    // Period and duty: 100 edges from release give 10 transitions, each 10 edges apart.
    run_edge(0, 1'b1, 1'b0, "period_reset");
    run_edge(0, 1'b1, 1'b0, "period_reset");
    @(negedge clk);
    rst_a = 1'b0;
    prev = led_a;
    last_edge = 0;
    toggles = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (led_a !== prev) begin
        toggles++;
        check_int("interval", e - last_edge, 10);
        last_edge = e;
        prev = led_a;
      end
    end
    check_int("toggle_count", toggles, 10);

    // Asynchronous reset mid-count with led high, then a clean restart.
    run_edge(0, 1'b1, 1'b0, "async_prep");
    run_edge(0, 1'b1, 1'b0, "async_prep");
    for (int e = 1; e <= 16; e++) begin
      run_edge(0, 1'b0, logic'(e >= 10), "async_count");
    end
    #4;
    rst_a = 1'b1;
    #1;
    check_bit("async_clear", led_a, 1'b0);
    run_edge(0, 1'b1, 1'b0, "async_hold");
    run_edge(0, 1'b1, 1'b0, "async_hold");
    for (int e = 1; e <= 10; e++) begin
      run_edge(0, 1'b0, logic'(e == 10), "async_restart");
    end

    check_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
